// File: rtl/argmax_seq.sv
// argmax_seq: sequential arg-max over a packed vector of class scores.
// A request captures all scores at once, then walks them one per clock in
// ascending index order, tracking the best and second-best values. The
// result (index, value, best-minus-second margin) is published with a
// single-cycle done pulse and held until the next result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; result outputs hold the last result
// ST_SCAN | comparing one captured element per clock
// ST_DONE | result just published (done high); back to idle next edge
module argmax_seq #(
    parameter int NUM_CLASS = 10,
    parameter int SCORE_W   = 8,
    parameter int IDX_W     = 10,
    parameter bit SIGNED    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_CLASS*SCORE_W-1:0]  scores,
    output logic                          busy,
    output logic                          done,
    output logic [IDX_W-1:0]              max_idx,
    output logic [SCORE_W-1:0]            max_val,
    output logic [SCORE_W:0]              margin
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    // Smallest representable score: seeds "second" so any real element beats it.
    localparam logic [SCORE_W-1:0] MIN_VAL  = SIGNED ? (SCORE_W'(1) << (SCORE_W - 1)) : SCORE_W'(0);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CLASS - 1);

    state_t                         state_q;
    logic [IDX_W-1:0]               cnt_q;
    logic [NUM_CLASS*SCORE_W-1:0]   shift_q;
    logic [SCORE_W-1:0]             best_q, best_d;
    logic [SCORE_W-1:0]             second_q, second_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [SCORE_W:0]               margin_d;
    logic [SCORE_W-1:0]             elem;
    logic                           busy_q, done_q;
    logic [IDX_W-1:0]               max_idx_q;
    logic [SCORE_W-1:0]             max_val_q;
    logic [SCORE_W:0]               margin_q;

    function automatic logic gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        if (SIGNED) return $signed(a) > $signed(b);
        else        return a > b;
    endfunction

    // One extra bit keeps best-minus-second from overflowing in either mode.
    function automatic logic [SCORE_W:0] ext(input logic [SCORE_W-1:0] v);
        return SIGNED ? {v[SCORE_W-1], v} : {1'b0, v};
    endfunction

    // Next best/second/index after folding in the current element; strict
    // compares keep the lowest index on ties and let a tie raise second to best.
    always_comb begin
        elem     = shift_q[SCORE_W-1:0];
        best_d   = best_q;
        second_d = second_q;
        idx_d    = idx_q;
        if (cnt_q == '0) begin
            best_d   = elem;
            second_d = MIN_VAL;
            idx_d    = '0;
        end else if (gt(elem, best_q)) begin
            second_d = best_q;
            best_d   = elem;
            idx_d    = cnt_q;
        end else if (gt(elem, second_q)) begin
            second_d = elem;
        end
        margin_d = (NUM_CLASS == 1) ? '0 : ext(best_d) - ext(second_d);
    end

    // Request sequencing, element walk and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            best_q    <= '0;
            second_q  <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            max_idx_q <= '0;
            max_val_q <= '0;
            margin_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shift_q <= scores;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    best_q   <= best_d;
                    second_q <= second_d;
                    idx_q    <= idx_d;
                    shift_q  <= shift_q >> SCORE_W;
                    cnt_q    <= cnt_q + IDX_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        max_idx_q <= idx_d;
                        max_val_q <= best_d;
                        margin_q  <= margin_d;
                        done_q    <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign max_idx = max_idx_q;
    assign max_val = max_val_q;
    assign margin  = margin_q;

endmodule

// File: tb/tb_argmax_seq.sv
// Directed bench for argmax_seq: signed 10-class build plus an unsigned build.
module tb_argmax_seq;

    logic        clk = 1'b0;
    logic        rst, start, u_start;
    logic [79:0] scores, u_scores;
    logic        busy, done, u_busy, u_done;
    logic [9:0]  max_idx, u_max_idx;
    logic [7:0]  max_val, u_max_val;
    logic [8:0]  margin, u_margin;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    argmax_seq #(.NUM_CLASS(10), .SCORE_W(8), .IDX_W(10), .SIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .scores(scores),
        .busy(busy), .done(done), .max_idx(max_idx), .max_val(max_val), .margin(margin)
    );

    argmax_seq #(.NUM_CLASS(10), .SCORE_W(8), .IDX_W(10), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(u_start), .scores(u_scores),
        .busy(u_busy), .done(u_done), .max_idx(u_max_idx), .max_val(u_max_val), .margin(u_margin)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] fill(input logic [7:0] v);
        logic [79:0] r;
        for (int i = 0; i < 10; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    // Accept a request on the signed DUT; returns just after the accepting edge.
    task automatic do_start(input logic [79:0] v);
        @(negedge clk);
        scores = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        scores = fill(8'h7F);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_case(input string tag, input logic [79:0] v,
                            input int e_idx, input int e_val, input int e_mrg);
        int lat;
        do_start(v);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'd10);
        check({tag, "_idx"},    32'(max_idx), 32'(e_idx));
        check({tag, "_val"},    32'(max_val), 32'(e_val));
        check({tag, "_margin"}, 32'(margin),  32'(e_mrg));
        @(posedge clk);
        #1;
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [79:0] v;
        logic [79:0] uv;
        int busy_cnt, done_cnt, lat;

        rst = 1'b1; start = 1'b0; u_start = 1'b0;
        scores = '0; u_scores = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy),    32'd0);
        check("rst_done",   32'(done),    32'd0);
        check("rst_idx",    32'(max_idx), 32'd0);
        check("rst_val",    32'(max_val), 32'd0);
        check("rst_margin", 32'(margin),  32'd0);
        check("rst_u_busy", 32'(u_busy),  32'd0);
        rst = 1'b0;

        // distinct scores, winner idx7=100, runner-up idx4=90
        v = '0;
        for (int k = 0; k < 10; k++) v[k*8 +: 8] = 8'(k * 5);
        v[4*8 +: 8] = 8'd90;
        v[7*8 +: 8] = 8'd100;
        run_case("distinct", v, 7, 100, 10);

        // tie at 50 between idx2 and idx5
        for (int k = 0; k < 10; k++) v[k*8 +: 8] = 8'(k);
        v[2*8 +: 8] = 8'd50;
        v[5*8 +: 8] = 8'd50;
        run_case("tie", v, 2, 50, 0);

        // all minimum
        run_case("allmin", fill(8'h80), 0, 8'h80, 0);

        // idx3=-1 others -100
        v = fill(8'h9C);
        v[3*8 +: 8] = 8'hFF;
        run_case("neg", v, 3, 8'hFF, 99);

        // unsigned build: 0x80 beats 0x7F
        uv = fill(8'h7F);
        uv[9*8 +: 8] = 8'h80;
        @(negedge clk);
        u_scores = uv;
        u_start  = 1'b1;
        @(posedge clk);
        #1;
        u_start  = 1'b0;
        u_scores = '0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (u_done) begin
                lat = k;
                break;
            end
        end
        check("uns_latency", 32'(lat),       32'd10);
        check("uns_idx",     32'(u_max_idx), 32'd9);
        check("uns_val",     32'(u_max_val), 32'h80);
        check("uns_margin",  32'(u_margin),  32'd1);

        // restart and score changes during SCAN are ignored
        v = '0;
        for (int k = 0; k < 10; k++) v[k*8 +: 8] = 8'(k * 5);
        v[4*8 +: 8] = 8'd90;
        v[7*8 +: 8] = 8'd100;
        do_start(v);
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (k == 3) begin
                start  = 1'b1;
                scores = fill(8'h7E);
            end
            if (k == 5) begin
                start = 1'b0;
                check("hold_idx",    32'(max_idx), 32'd3);
                check("hold_margin", 32'(margin),  32'd99);
            end
        end
        start = 1'b0;
        check("restart_busy_cycles", 32'(busy_cnt), 32'd11);
        check("restart_done_count",  32'(done_cnt), 32'd1);
        check("restart_idx",         32'(max_idx),  32'd7);
        check("restart_val",         32'(max_val),  32'd100);
        check("restart_margin",      32'(margin),   32'd10);

        // reset on the 4th SCAN edge aborts the request
        v = '0;
        v[0*8 +: 8] = 8'hFB;
        v[1*8 +: 8] = 8'd19;
        v[8*8 +: 8] = 8'd20;
        do_start(v);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy",   32'(busy),    32'd0);
        check("abort_done",   32'(done),    32'd0);
        check("abort_idx",    32'(max_idx), 32'd0);
        check("abort_val",    32'(max_val), 32'd0);
        check("abort_margin", 32'(margin),  32'd0);
        done_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_case("after_rst", v, 8, 20, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
